// File: rtl/dn_pkg.sv
// dn_pkg: shared state type and index helpers for the distribution-network controller
package dn_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    function automatic int n_stage(input int n_port);
        return $clog2(n_port);
    endfunction
    function automatic int route_idx(input int stage, input int router, input int n_port);
        return stage * n_port + 2 * router;
    endfunction
endpackage

// File: rtl/dn_vld_pipe.sv
// dn_vld_pipe: beat-valid shift register, one bit per stage past the first plus out_valid
module dn_vld_pipe #(
    parameter int N_STAGE = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               vld_in,
    output logic [N_STAGE-1:0] stg
);
    logic [N_STAGE-1:0] stg_q, stg_d;
    always_comb stg_d = N_STAGE'({stg_q, vld_in});
    always_ff @(posedge clk) stg_q <= clr ? '0 : stg_d;
    assign stg = stg_q;
endmodule

// File: rtl/dn_ctrl.sv
// dn_ctrl: config handshake, beat admission and per-stage enables for one distribution network
module dn_ctrl
    import dn_pkg::*;
#(
    parameter int N_PORT = 8,
    parameter int DW_CNT = 8,
    localparam int N_STAGE = n_stage(N_PORT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [N_STAGE*N_PORT-1:0] cfg_route,
    input  logic [DW_CNT-1:0]         cfg_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N_STAGE-1:0]        set_en,
    output logic [N_STAGE-1:0]        route_en,
    output logic [N_STAGE*N_PORT-1:0] route_signal,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done
);
    state_t                    state_q, state_d;
    logic [DW_CNT-1:0]         rem_q, rem_d;
    logic [N_STAGE*N_PORT-1:0] route_q, route_d;
    logic [N_STAGE-1:0]        stg;
    logic                      acc, en;

    dn_vld_pipe #(.N_STAGE(N_STAGE)) u_pipe (
        .clk    (clk),
        .clr    (reset),
        .vld_in (acc),
        .stg    (stg)
    );

    assign acc          = in_valid & in_ready;
    assign set_en       = N_STAGE'({stg, acc});
    assign out_valid    = stg[N_STAGE-1];
    assign route_en     = {N_STAGE{en}};
    assign route_signal = route_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        route_d   = route_q;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        en        = 1'b1;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                en        = 1'b0;
                if (cfg_valid) begin
                    route_d = cfg_route;
                    rem_d   = cfg_len;
                    state_d = (cfg_len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                in_ready = rem_q != '0;
                if (acc) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == DW_CNT'(1)) ? DRAIN : STREAM;
                end
            end
            // set_en[0] is idle here, so an empty set_en means the final beat sits at the outputs
            DRAIN: state_d = (out_valid && set_en == '0) ? DONE : DRAIN;
            default: begin
                done    = 1'b1;
                en      = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            route_q <= route_d;
        end
    end
endmodule
